// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer between the execute stage, memory_interface and writeback.
// Latency: o_valid 3 cycles after the accept edge for memory accesses, 1 cycle for locally detected exceptions.
// Backpressure: one request in flight; o_ready is low outside IDLE; the result is held in DONE until i_ready.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   i_valid / o_ready     request handshake from execute (is_store, funct3, base, offset, store data)
//   o_mem_req_*           one-cycle request to memory_interface (addr, wr_data, count, wr_en)
//   i_mem_res_*           response from memory_interface, sampled one cycle after the request
//   o_valid / i_ready     result handshake to writeback (result, exception flags, effective address)
module load_store_unit #(
    parameter int ADDR_W      = 32,
    parameter int WORD_W      = 32,
    parameter int MEM_COUNT_W = 2,
    parameter int MEM_CODE_W  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic                   i_is_store,
    input  logic [2:0]             i_funct3,
    input  logic [ADDR_W-1:0]      i_base,
    input  logic [11:0]            i_offset,
    input  logic [WORD_W-1:0]      i_store_data,
    output logic [ADDR_W-1:0]      o_mem_req_addr,
    output logic [WORD_W-1:0]      o_mem_req_wr_data,
    output logic [MEM_COUNT_W-1:0] o_mem_req_count,
    output logic                   o_mem_req_wr_en,
    input  logic [WORD_W-1:0]      i_mem_res_rd_data,
    input  logic [MEM_CODE_W-1:0]  i_mem_res_code,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [WORD_W-1:0]      o_result,
    output logic                   o_exc_misaligned,
    output logic                   o_exc_illegal,
    output logic [ADDR_W-1:0]      o_exc_addr
);

    // Encodings shared with memory_interface (mem_codes.vh).
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = MEM_COUNT_W'(0);
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = MEM_COUNT_W'(1);
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = MEM_COUNT_W'(2);
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = MEM_COUNT_W'(3);
    localparam logic [MEM_CODE_W-1:0]  MEM_CODE_READ       = MEM_CODE_W'(1);
    localparam logic [MEM_CODE_W-1:0]  MEM_CODE_WRITE      = MEM_CODE_W'(2);
    localparam logic [MEM_CODE_W-1:0]  MEM_CODE_MISALIGNED = MEM_CODE_W'(3);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                 state_q;
    logic                   is_store_q;
    logic [2:0]             funct3_q;
    logic [ADDR_W-1:0]      req_addr_q;
    logic [WORD_W-1:0]      req_wr_data_q;
    logic [MEM_COUNT_W-1:0] req_count_q;
    logic                   req_wr_en_q;
    logic                   valid_q;
    logic [WORD_W-1:0]      result_q;
    logic                   exc_mis_q;
    logic                   exc_ill_q;
    logic [ADDR_W-1:0]      exc_addr_q;

    // Decode of the request presented on the execute side.
    logic [ADDR_W-1:0]      ea_d;
    logic [MEM_COUNT_W-1:0] count_d;
    logic                   illegal_d;
    logic                   misaligned_d;

    assign ea_d = i_base + {{(ADDR_W-12){i_offset[11]}}, i_offset};

    always_comb begin
        count_d   = MEM_COUNT_NONE;
        illegal_d = 1'b0;
        case (i_funct3)
            3'd0:    count_d = MEM_COUNT_BYTE;
            3'd1:    count_d = MEM_COUNT_HALF;
            3'd2:    count_d = MEM_COUNT_WORD;
            // Unsigned widths only make sense for loads.
            3'd4: begin
                count_d   = MEM_COUNT_BYTE;
                illegal_d = i_is_store;
            end
            3'd5: begin
                count_d   = MEM_COUNT_HALF;
                illegal_d = i_is_store;
            end
            default: illegal_d = 1'b1;
        endcase
        // An illegal encoding is reported alone; alignment is meaningless without a width.
        misaligned_d = 1'b0;
        if (!illegal_d) begin
            if (count_d == MEM_COUNT_HALF) begin
                misaligned_d = ea_d[0];
            end else if (count_d == MEM_COUNT_WORD) begin
                misaligned_d = |ea_d[1:0];
            end
        end
    end

    // Response classification. A MISALIGNED code is reported only as misaligned,
    // any other code that does not match the request type is reported as illegal.
    logic [MEM_CODE_W-1:0] code_expected;
    logic                  resp_mis;
    logic                  resp_ill;
    logic [WORD_W-1:0]     load_ext;

    assign code_expected = is_store_q ? MEM_CODE_WRITE : MEM_CODE_READ;
    assign resp_mis      = (i_mem_res_code == MEM_CODE_MISALIGNED);
    assign resp_ill      = !resp_mis && (i_mem_res_code != code_expected);

    always_comb begin
        load_ext = i_mem_res_rd_data;
        case (funct3_q)
            3'd0:    load_ext = {{(WORD_W-8){i_mem_res_rd_data[7]}}, i_mem_res_rd_data[7:0]};
            3'd1:    load_ext = {{(WORD_W-16){i_mem_res_rd_data[15]}}, i_mem_res_rd_data[15:0]};
            3'd4:    load_ext = {{(WORD_W-8){1'b0}}, i_mem_res_rd_data[7:0]};
            3'd5:    load_ext = {{(WORD_W-16){1'b0}}, i_mem_res_rd_data[15:0]};
            default: load_ext = i_mem_res_rd_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            is_store_q    <= 1'b0;
            funct3_q      <= 3'd0;
            req_addr_q    <= '0;
            req_wr_data_q <= '0;
            req_count_q   <= MEM_COUNT_NONE;
            req_wr_en_q   <= 1'b0;
            valid_q       <= 1'b0;
            result_q      <= '0;
            exc_mis_q     <= 1'b0;
            exc_ill_q     <= 1'b0;
            exc_addr_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_valid) begin
                        is_store_q <= i_is_store;
                        funct3_q   <= i_funct3;
                        exc_addr_q <= ea_d;
                        if (illegal_d || misaligned_d) begin
                            state_q   <= S_DONE;
                            valid_q   <= 1'b1;
                            exc_ill_q <= illegal_d;
                            exc_mis_q <= misaligned_d;
                            result_q  <= '0;
                        end else begin
                            state_q       <= S_ISSUE;
                            req_addr_q    <= ea_d;
                            req_wr_data_q <= i_store_data;
                            req_count_q   <= count_d;
                            req_wr_en_q   <= i_is_store;
                        end
                    end
                end
                S_ISSUE: begin
                    // The request is a single-cycle pulse.
                    state_q       <= S_WAIT;
                    req_addr_q    <= '0;
                    req_wr_data_q <= '0;
                    req_count_q   <= MEM_COUNT_NONE;
                    req_wr_en_q   <= 1'b0;
                end
                S_WAIT: begin
                    state_q   <= S_DONE;
                    valid_q   <= 1'b1;
                    exc_mis_q <= resp_mis;
                    exc_ill_q <= resp_ill;
                    result_q  <= (is_store_q || resp_mis || resp_ill) ? '0 : load_ext;
                end
                S_DONE: begin
                    if (i_ready) begin
                        state_q   <= S_IDLE;
                        valid_q   <= 1'b0;
                        exc_mis_q <= 1'b0;
                        exc_ill_q <= 1'b0;
                        result_q  <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_ready           = (state_q == S_IDLE);
    assign o_mem_req_addr    = req_addr_q;
    assign o_mem_req_wr_data = req_wr_data_q;
    assign o_mem_req_count   = req_count_q;
    assign o_mem_req_wr_en   = req_wr_en_q;
    assign o_valid           = valid_q;
    assign o_result          = result_q;
    assign o_exc_misaligned  = exc_mis_q;
    assign o_exc_illegal     = exc_ill_q;
    assign o_exc_addr        = exc_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed stimulus for load_store_unit with a byte-array memory
// and a transaction-level expectation model; one negedge process compares every cycle.
// Directed cases pin the model with literal values.
module tb_load_store_unit;

    localparam logic [1:0] CNT_NONE = 2'd0;
    localparam logic [1:0] CODE_READ = 2'd1;
    localparam logic [1:0] CODE_WRITE = 2'd2;
    localparam logic [1:0] CODE_MIS = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_is_store = 1'b0;
    logic [2:0]  i_funct3 = 3'd0;
    logic [31:0] i_base = 32'd0;
    logic [11:0] i_offset = 12'd0;
    logic [31:0] i_store_data = 32'd0;
    logic [31:0] o_mem_req_addr;
    logic [31:0] o_mem_req_wr_data;
    logic [1:0]  o_mem_req_count;
    logic        o_mem_req_wr_en;
    logic [31:0] i_mem_res_rd_data = 32'd0;
    logic [1:0]  i_mem_res_code = 2'd0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_result;
    logic        o_exc_misaligned;
    logic        o_exc_illegal;
    logic [31:0] o_exc_addr;

    load_store_unit dut (
        .clk               (clk),
        .reset             (reset),
        .i_valid           (i_valid),
        .o_ready           (o_ready),
        .i_is_store        (i_is_store),
        .i_funct3          (i_funct3),
        .i_base            (i_base),
        .i_offset          (i_offset),
        .i_store_data      (i_store_data),
        .o_mem_req_addr    (o_mem_req_addr),
        .o_mem_req_wr_data (o_mem_req_wr_data),
        .o_mem_req_count   (o_mem_req_count),
        .o_mem_req_wr_en   (o_mem_req_wr_en),
        .i_mem_res_rd_data (i_mem_res_rd_data),
        .i_mem_res_code    (i_mem_res_code),
        .o_valid           (o_valid),
        .i_ready           (i_ready),
        .o_result          (o_result),
        .o_exc_misaligned  (o_exc_misaligned),
        .o_exc_illegal     (o_exc_illegal),
        .o_exc_addr        (o_exc_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mem [logic [31:0]];

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit is_legal(input bit st, input logic [2:0] f3);
        return (size_of(f3) != 0) && !(st && (f3 == 3'd4 || f3 == 3'd5));
    endfunction

    function automatic logic [1:0] count_code(input int sz);
        return (sz == 1) ? 2'd1 : (sz == 2) ? 2'd2 : 2'd3;
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a, input int n);
        logic [31:0] r;
        logic [31:0] ai;
        r = 32'd0;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            if (mem.exists(ai)) r = r | (32'(mem[ai]) << (8 * i));
        end
        return r;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
        logic [31:0] b;
        logic [31:0] h;
        b = raw & 32'hff;
        h = raw & 32'hffff;
        case (f3)
            3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return raw;
        endcase
    endfunction

    // Current transaction as seen by the model.
    bit          t_act = 0;
    int          t_acc = 0;
    bit          t_st;
    logic [2:0]  t_f3;
    logic [31:0] t_ea;
    logic [31:0] t_data;
    int          t_sz;
    bit          t_loc;
    logic [31:0] t_res;
    bit          t_mis;
    bit          t_ill;
    bit          armed = 0;
    bit          just_reset = 0;
    bit          resp_hold = 0;
    int          err_pct = 0;
    logic [1:0]  m_code;
    logic [31:0] m_raw;
    bit          vexp;

    // Compare process: checks the current cycle, plays memory, then advances the model.
    always @(negedge clk) begin
        if (armed) begin
            if (!t_act) begin
                chk("ready_idle", 32'(o_ready), 32'd1);
                chk("valid_idle", 32'(o_valid), 32'd0);
                chk("req_cnt_idle", 32'(o_mem_req_count), 32'(CNT_NONE));
                chk("req_wr_en_idle", 32'(o_mem_req_wr_en), 32'd0);
                chk("req_addr_idle", o_mem_req_addr, 32'd0);
                chk("req_data_idle", o_mem_req_wr_data, 32'd0);
                if (just_reset) begin
                    chk("reset_result", o_result, 32'd0);
                    chk("reset_mis", 32'(o_exc_misaligned), 32'd0);
                    chk("reset_ill", 32'(o_exc_illegal), 32'd0);
                end
            end else begin
                chk("ready_busy", 32'(o_ready), 32'd0);
                if (!t_loc && cyc == t_acc) begin
                    chk("req_cnt", 32'(o_mem_req_count), 32'(count_code(t_sz)));
                    chk("req_wr_en", 32'(o_mem_req_wr_en), 32'(t_st));
                    chk("req_addr", o_mem_req_addr, t_ea);
                    chk("req_data", o_mem_req_wr_data, t_data);
                end else begin
                    chk("req_cnt_none", 32'(o_mem_req_count), 32'(CNT_NONE));
                    chk("req_wr_en_none", 32'(o_mem_req_wr_en), 32'd0);
                end
                vexp = (cyc >= t_acc + (t_loc ? 0 : 2));
                chk("valid", 32'(o_valid), 32'(vexp));
                if (vexp) begin
                    chk("result", o_result, t_res);
                    chk("exc_mis", 32'(o_exc_misaligned), 32'(t_mis));
                    chk("exc_ill", 32'(o_exc_illegal), 32'(t_ill));
                    chk("exc_addr", o_exc_addr, t_ea);
                end
            end
        end

        // Memory: respond to the request seen in ISSUE and keep it through WAIT.
        if (t_act && !t_loc && cyc == t_acc) begin
            m_code = t_st ? CODE_WRITE : CODE_READ;
            if ($urandom_range(99) < err_pct) m_code = 2'($urandom_range(3));
            m_raw = t_st ? 32'd0 : mem_read(t_ea, t_sz);
            t_res = 32'd0;
            t_mis = 0;
            t_ill = 0;
            if (m_code == CODE_MIS) t_mis = 1;
            else if (m_code != (t_st ? CODE_WRITE : CODE_READ)) t_ill = 1;
            else if (t_st) begin
                for (int i = 0; i < t_sz; i++) mem[t_ea + 32'(i)] = t_data[8*i +: 8];
            end else t_res = extend(m_raw, t_f3);
            i_mem_res_code = m_code;
            i_mem_res_rd_data = m_raw;
            resp_hold = 1;
        end else if (resp_hold) begin
            resp_hold = 0;
        end else begin
            i_mem_res_code = 2'($urandom_range(3));
            i_mem_res_rd_data = $urandom();
        end

        if (reset) begin
            armed = 1;
            just_reset = 1;
            t_act = 0;
        end else begin
            just_reset = 0;
            if (t_act && (cyc >= t_acc + (t_loc ? 0 : 2)) && i_ready) begin
                t_act = 0;
            end else if (!t_act && i_valid) begin
                t_act = 1;
                t_acc = cyc + 1;
                t_st = i_is_store;
                t_f3 = i_funct3;
                t_ea = i_base + 32'($signed(i_offset));
                t_data = i_store_data;
                t_sz = size_of(i_funct3);
                t_ill = !is_legal(i_is_store, i_funct3);
                t_mis = !t_ill && ((t_ea % 32'(t_sz)) != 0);
                t_loc = t_ill || t_mis;
                t_res = 32'd0;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] r_res, r_ea, r_iaddr;
    logic        r_mis, r_ill, r_iwr;
    logic [1:0]  r_icnt;
    int          r_lat, r_issues;

    // Called at posedge+2 with the DUT idle; returns what the DUT showed.
    task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] base,
                          input logic [11:0] off, input logic [31:0] data, input int hold);
        i_valid = 1; i_is_store = st; i_funct3 = f3; i_base = base; i_offset = off;
        i_store_data = data; i_ready = 0;
        @(posedge clk); #2;
        i_valid = 0; i_base = $urandom(); i_store_data = $urandom();
        r_lat = 0; r_issues = 0; r_res = 0; r_mis = 0; r_ill = 0; r_ea = 0;
        r_iaddr = 0; r_icnt = 0; r_iwr = 0;
        for (int k = 1; k <= 10 && r_lat == 0; k++) begin
            if (o_mem_req_count != CNT_NONE) begin
                r_issues++; r_iaddr = o_mem_req_addr; r_icnt = o_mem_req_count;
                r_iwr = o_mem_req_wr_en;
            end
            if (o_valid) r_lat = k;
            else begin
                @(posedge clk); #2;
            end
        end
        if (r_lat == 0) begin
            checks++; failures++;
            $display("FAIL op_timeout: o_valid still 0 after 10 cycles, required 1");
            return;
        end
        r_res = o_result; r_mis = o_exc_misaligned; r_ill = o_exc_illegal; r_ea = o_exc_addr;
        for (int h = 0; h < hold; h++) begin
            i_valid = 1; i_is_store = 1'($urandom()); i_funct3 = 3'($urandom());
            @(posedge clk); #2;
            chk("hold_ready", 32'(o_ready), 32'd0);
            chk("hold_valid", 32'(o_valid), 32'd1);
        end
        i_valid = 0; i_ready = 1;
        @(posedge clk); #2;
        i_ready = 0;
    endtask

    initial begin
        int o;
        repeat (3) @(posedge clk);
        #2 reset = 0;
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_cnt", 32'(o_mem_req_count), 32'(CNT_NONE));

        // SW base 0x40 offset -4
        run_op(1, 3'd2, 32'h40, 12'hffc, 32'hdeadbeef, 0);
        chk("sw_lat", 32'(r_lat), 32'd3);
        chk("sw_issues", 32'(r_issues), 32'd1);
        chk("sw_addr", r_iaddr, 32'h3c);
        chk("sw_cnt", 32'(r_icnt), 32'd3);
        chk("sw_wr_en", 32'(r_iwr), 32'd1);
        chk("sw_result", r_res, 32'd0);

        // SB 0x80 at 0x41, then LB / LBU
        run_op(1, 3'd0, 32'h41, 12'h000, 32'h80, 0);
        run_op(0, 3'd0, 32'h41, 12'h000, 32'h0, 0);
        chk("lb_result", r_res, 32'hffffff80);
        run_op(0, 3'd4, 32'h41, 12'h000, 32'h0, 0);
        chk("lbu_result", r_res, 32'h00000080);

        // LH at 0x43: local misaligned
        run_op(0, 3'd1, 32'h40, 12'h003, 32'h0, 0);
        chk("lh_mis_lat", 32'(r_lat), 32'd1);
        chk("lh_mis_issues", 32'(r_issues), 32'd0);
        chk("lh_mis_flag", 32'(r_mis), 32'd1);
        chk("lh_mis_addr", r_ea, 32'h43);

        // Illegal encodings
        run_op(0, 3'd3, 32'h40, 12'h000, 32'h0, 0);
        chk("ld_f3_3_ill", 32'(r_ill), 32'd1);
        run_op(1, 3'd5, 32'h40, 12'h000, 32'h1234, 0);
        chk("st_f3_5_ill", 32'(r_ill), 32'd1);
        chk("st_f3_5_issues", 32'(r_issues), 32'd0);

        // Writeback stall for 5 cycles with new requests pending
        run_op(0, 3'd2, 32'h3c, 12'h000, 32'h0, 5);
        chk("lw_stall_result", r_res, 32'hdeadbeef);
        run_op(0, 3'd1, 32'h3c, 12'h002, 32'h0, 0);
        chk("lh_result", r_res, 32'hffffdead);

        // Reset during WAIT
        i_valid = 1; i_is_store = 0; i_funct3 = 3'd2; i_base = 32'h3c; i_offset = 12'h0;
        @(posedge clk); #2;
        i_valid = 0;
        @(posedge clk); #2;
        reset = 1;
        @(posedge clk); #2;
        reset = 0;
        chk("wait_rst_valid", 32'(o_valid), 32'd0);
        chk("wait_rst_ready", 32'(o_ready), 32'd1);
        chk("wait_rst_cnt", 32'(o_mem_req_count), 32'(CNT_NONE));
        chk("wait_rst_result", o_result, 32'd0);
        run_op(0, 3'd2, 32'h3c, 12'h000, 32'h0, 0);
        chk("after_rst_lat", 32'(r_lat), 32'd3);
        chk("after_rst_result", r_res, 32'hdeadbeef);

        // Randomized traffic, with occasional bad response codes
        err_pct = 15;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(7) == 0) begin
                run_op(1'($urandom()), 3'($urandom()), $urandom(), 12'($urandom()), $urandom(),
                       $urandom_range(3));
            end else begin
                o = $urandom_range(63) - 32;
                run_op(1'($urandom()), 3'($urandom()), 32'h1000 + 32'($urandom_range(63)),
                       o[11:0], $urandom(), $urandom_range(3));
            end
        end

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
